// File: rtl/fetch_controller_pkg.sv
// Shared constants, state encodings and decode helpers for the IF-stage fetch controller.
package fetch_controller_pkg;

  localparam int Num_of_bits      = 16;
  localparam int pc_width         = 32;
  localparam int Num_of_registers = 5;
  localparam int CNT_W            = 16;
  localparam int IMM_FLAG_BIT     = 15;
  localparam int OPCODE_MSB       = 15;
  localparam int OPCODE_LSB       = 11;

  localparam logic [4:0]          HALT_OPCODE = 5'b00001;
  localparam logic [pc_width-1:0] RESET_PC    = '0;
  localparam logic [pc_width-1:0] ADDR_MASK   =
    {{(pc_width-Num_of_registers){1'b0}}, {Num_of_registers{1'b1}}};

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  typedef enum logic [1:0] {NPC_RESET, NPC_HOLD, NPC_SEQ, NPC_BRANCH} npc_sel_t;

  function automatic logic is_halt(input logic [Num_of_bits-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Memory-side and IF/ID-side signal bundle of the fetch controller.
interface fetch_controller_if;
  import fetch_controller_pkg::*;

  logic                   stall;
  logic                   branch_taken;
  logic [pc_width-1:0]    branch_target;
  logic [Num_of_bits-1:0] mem_instr;
  logic [Num_of_bits-1:0] mem_imm;
  logic [pc_width-1:0]    mem_pc;
  logic [Num_of_bits-1:0] if_instr;
  logic [Num_of_bits-1:0] if_imm;
  logic [pc_width-1:0]    if_pc;
  logic                   if_valid;
  logic                   if_two_word;
  logic                   halted;
  logic                   fault;
  logic [CNT_W-1:0]       fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, mem_instr, mem_imm,
    output mem_pc, if_instr, if_imm, if_pc, if_valid, if_two_word,
           halted, fault, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, mem_instr, mem_imm,
    input  mem_pc, if_instr, if_imm, if_pc, if_valid, if_two_word,
           halted, fault, fetch_count
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next memory address mux; the result is always folded into the memory depth.
module fetch_next_pc
  import fetch_controller_pkg::*;
(
  input  npc_sel_t            sel,
  input  logic [pc_width-1:0] cur_pc,
  input  logic [pc_width-1:0] branch_target,
  input  logic                two_word,
  output logic [pc_width-1:0] next_pc
);

  logic [pc_width-1:0] raw_pc;

  always_comb begin
    raw_pc = cur_pc;
    case (sel)
      NPC_RESET:  raw_pc = RESET_PC;
      NPC_HOLD:   raw_pc = cur_pc;
      NPC_SEQ:    raw_pc = cur_pc + (two_word ? pc_width'(2) : pc_width'(1));
      NPC_BRANCH: raw_pc = branch_target;
      default:    raw_pc = cur_pc;
    endcase
    next_pc = raw_pc & ADDR_MASK;
  end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: boot/run/halt FSM, fault latch and saturating fetch counter.
module fetch_controller
  import fetch_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master bus
);

  state_t              state, state_nxt;
  npc_sel_t            npc_sel;
  logic [pc_width-1:0] cur_pc;
  logic [CNT_W-1:0]    fetch_count;
  logic                fault_q;
  logic                two_word;
  logic                valid;
  logic                fault_now;
  logic                accept;

  assign two_word = bus.mem_instr[IMM_FLAG_BIT];
  assign accept   = valid & ~bus.stall;

  fetch_next_pc u_next_pc (
    .sel           (npc_sel),
    .cur_pc        (cur_pc),
    .branch_target (bus.branch_target),
    .two_word      (two_word),
    .next_pc       (bus.mem_pc)
  );

  // cur_pc always follows the issued address so it names the words arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      cur_pc      <= RESET_PC;
      fault_q     <= 1'b0;
      fetch_count <= '0;
    end else begin
      state  <= state_nxt;
      cur_pc <= bus.mem_pc;
      if (fault_now)
        fault_q <= 1'b1;
      if (accept && fetch_count != '1)
        fetch_count <= fetch_count + 1'b1;
    end
  end

  // Priority in run: branch kill, then last-address fault, then stall, then halt/advance.
  always_comb begin
    state_nxt = state;
    npc_sel   = NPC_HOLD;
    valid     = 1'b0;
    fault_now = 1'b0;
    if (rst) begin
      npc_sel = NPC_RESET;
    end else begin
      case (state)
        S_BOOT: begin
          npc_sel   = NPC_RESET;
          state_nxt = S_RUN;
        end
        S_RUN: begin
          if (bus.branch_taken) begin
            npc_sel = NPC_BRANCH;
          end else if (two_word && cur_pc == ADDR_MASK) begin
            fault_now = 1'b1;
            state_nxt = S_HALT;
          end else if (bus.stall) begin
            valid = 1'b1;
          end else begin
            valid   = 1'b1;
            npc_sel = NPC_SEQ;
            if (is_halt(bus.mem_instr))
              state_nxt = S_HALT;
          end
        end
        S_HALT: begin
          if (bus.branch_taken) begin
            npc_sel   = NPC_BRANCH;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  assign bus.if_instr    = bus.mem_instr;
  assign bus.if_imm      = bus.mem_imm;
  assign bus.if_pc       = cur_pc;
  assign bus.if_valid    = valid;
  assign bus.if_two_word = two_word;
  assign bus.halted      = (state == S_HALT) && !rst;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: vector table through a scoreboard plus corner sequences.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] mem [32];
  int total = 0;
  int bad   = 0;

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered instruction memory: words for the address issued at the previous edge.
  always @(posedge clk) begin
    bus.mem_instr <= mem[bus.mem_pc[4:0]];
    bus.mem_imm   <= mem[5'(bus.mem_pc[4:0] + 5'd1)];
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] pc;
    logic [15:0] instr;
    logic        two;
    logic [15:0] imm;
    logic [31:0] mpc;
    logic        halted;
    logic        fault;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [21];
  vec_t expq [$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.rst, v.stall, v.br, v.tgt);
    expq.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    #3;
    e = expq.pop_front();
    cmp($sformatf("v%0d if_valid", idx), 32'(bus.if_valid), 32'(e.valid));
    cmp($sformatf("v%0d mem_pc", idx), bus.mem_pc, e.mpc);
    cmp($sformatf("v%0d halted", idx), 32'(bus.halted), 32'(e.halted));
    cmp($sformatf("v%0d fault", idx), 32'(bus.fault), 32'(e.fault));
    cmp($sformatf("v%0d fetch_count", idx), 32'(bus.fetch_count), 32'(e.cnt));
    if (e.valid) begin
      cmp($sformatf("v%0d if_pc", idx), bus.if_pc, e.pc);
      cmp($sformatf("v%0d if_instr", idx), 32'(bus.if_instr), 32'(e.instr));
      cmp($sformatf("v%0d if_two_word", idx), 32'(bus.if_two_word), 32'(e.two));
      if (e.two)
        cmp($sformatf("v%0d if_imm", idx), 32'(bus.if_imm), 32'(e.imm));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0010;
    mem[1]  = 16'h8020;
    mem[2]  = 16'h1234;
    mem[3]  = 16'h0030;
    mem[4]  = 16'h0800;
    mem[31] = 16'h8000;

    // rst stall br tgt | valid pc instr two imm mem_pc halted fault cnt
    vecs[0]  = '{1, 0, 0,  0, 0,  0, 16'h0000, 0, 16'h0000,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,  0, 0,  0, 16'h0000, 0, 16'h0000,  0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0,  0, 1,  0, 16'h0010, 0, 16'h0000,  1, 0, 0, 0};
    vecs[3]  = '{0, 1, 0,  0, 1,  1, 16'h8020, 1, 16'h1234,  1, 0, 0, 1};
    vecs[4]  = '{0, 1, 0,  0, 1,  1, 16'h8020, 1, 16'h1234,  1, 0, 0, 1};
    vecs[5]  = '{0, 1, 0,  0, 1,  1, 16'h8020, 1, 16'h1234,  1, 0, 0, 1};
    vecs[6]  = '{0, 0, 0,  0, 1,  1, 16'h8020, 1, 16'h1234,  3, 0, 0, 1};
    vecs[7]  = '{0, 1, 1, 20, 0,  3, 16'h0030, 0, 16'h0000, 20, 0, 0, 2};
    vecs[8]  = '{0, 0, 0,  0, 1, 20, 16'h0010, 0, 16'h0000, 21, 0, 0, 2};
    vecs[9]  = '{0, 0, 1,  4, 0, 21, 16'h0010, 0, 16'h0000,  4, 0, 0, 3};
    vecs[10] = '{0, 0, 0,  0, 1,  4, 16'h0800, 0, 16'h0000,  5, 0, 0, 3};
    vecs[11] = '{0, 0, 0,  0, 0,  5, 16'h0000, 0, 16'h0000,  5, 1, 0, 4};
    vecs[12] = '{0, 0, 0,  0, 0,  5, 16'h0000, 0, 16'h0000,  5, 1, 0, 4};
    vecs[13] = '{0, 0, 1,  0, 0,  5, 16'h0000, 0, 16'h0000,  0, 1, 0, 4};
    vecs[14] = '{0, 0, 0,  0, 1,  0, 16'h0010, 0, 16'h0000,  1, 0, 0, 4};
    vecs[15] = '{0, 0, 1, 31, 0,  1, 16'h0000, 0, 16'h0000, 31, 0, 0, 5};
    vecs[16] = '{0, 0, 0,  0, 0, 31, 16'h0000, 0, 16'h0000, 31, 0, 0, 5};
    vecs[17] = '{0, 0, 0,  0, 0, 31, 16'h0000, 0, 16'h0000, 31, 1, 1, 5};
    vecs[18] = '{1, 0, 0,  0, 0,  0, 16'h0000, 0, 16'h0000,  0, 0, 1, 5};
    vecs[19] = '{0, 0, 0,  0, 0,  0, 16'h0000, 0, 16'h0000,  0, 0, 0, 0};
    vecs[20] = '{0, 0, 0,  0, 1,  0, 16'h0010, 0, 16'h0000,  1, 0, 0, 0};

    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // One-word instruction at the last address wraps to 0.
    mem[31] = 16'h0010;
    drive(0, 0, 1, 31);
    #3 cmp("wrap branch mem_pc", bus.mem_pc, 32'd31);
    drive(0, 0, 0, 0);
    #3 cmp("wrap pc31 if_pc", bus.if_pc, 32'd31);
    cmp("wrap pc31 valid", 32'(bus.if_valid), 32'd1);
    cmp("wrap pc31 mem_pc", bus.mem_pc, 32'd0);
    drive(0, 0, 0, 0);
    #3 cmp("wrap pc0 if_pc", bus.if_pc, 32'd0);
    cmp("wrap pc0 valid", 32'(bus.if_valid), 32'd1);

    // Two-word instruction at address 30 wraps past the end without faulting.
    mem[30] = 16'h8000;
    drive(0, 0, 1, 30);
    drive(0, 0, 0, 0);
    #3 cmp("pc30 two_word", 32'(bus.if_two_word), 32'd1);
    cmp("pc30 mem_pc", bus.mem_pc, 32'd0);
    cmp("pc30 valid", 32'(bus.if_valid), 32'd1);
    drive(0, 0, 0, 0);
    #3 cmp("pc30 fault", 32'(bus.fault), 32'd0);
    cmp("pc30 next if_pc", bus.if_pc, 32'd0);

    // Saturating counter: run long enough to exceed 0xFFFF accepted fetches.
    mem[4] = 16'h0010;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    repeat (65540) @(posedge clk);
    #4 cmp("sat count", 32'(bus.fetch_count), 32'h0000FFFF);
    cmp("sat valid", 32'(bus.if_valid), 32'd1);
    @(posedge clk);
    #4 cmp("sat count hold", 32'(bus.fetch_count), 32'h0000FFFF);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    #3 cmp("sat count reset", 32'(bus.fetch_count), 32'd0);
    cmp("sat reset valid", 32'(bus.if_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the instruction memory for the IF stage of the five-stage pipeline. It drives the memory address, handles variable-length instructions (one word, or an instruction word plus an immediate word), stalls, branch redirects and halt, and presents a valid or killed instruction to the IF/ID register. One instruction per cycle; no bubbles for two-word instructions.

Parameters:
Num_of_bits, 16, instruction/immediate word width
pc_width, 32, PC width
Num_of_registers, 5, memory address bits (depth 2**Num_of_registers)
RESET_PC, 0, first fetch address after reset
IMM_FLAG_BIT, 15, instruction bit set means two-word instruction
HALT_OPCODE, 5'b00001, value of instr[15:11] for HLT (one-word)
CNT_W, 16, fetch counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: IF/ID cannot accept this cycle
branch_taken  in  1  redirect request from EX
branch_target  in  pc_width  redirect address
mem_instr  in  Num_of_bits  memory word at last issued address (registered in memory)
mem_imm  in  Num_of_bits  memory word at last issued address + 1
mem_pc  out  pc_width  address to memory, combinational, upper bits zero
if_instr  out  Num_of_bits  instruction to IF/ID
if_imm  out  Num_of_bits  immediate to IF/ID (valid only if if_two_word)
if_pc  out  pc_width  address of if_instr
if_valid  out  1  if_instr is a live instruction
if_two_word  out  1  instr[IMM_FLAG_BIT]
halted  out  1  controller in S_HALT
fault  out  1  sticky: two-word instruction at last address
fetch_count  out  CNT_W  accepted instructions, saturating

Behaviour:
- Memory model: address presented on mem_pc is captured at posedge; words appear the next cycle. Register cur_pc tracks the address of the words on mem_instr/mem_imm.
- States: S_BOOT, S_RUN, S_HALT. rst high at a posedge -> S_BOOT, cur_pc=RESET_PC, fault=0, fetch_count=0.
- Outputs while rst is high and in S_BOOT: if_valid=0, halted=0, mem_pc=RESET_PC. S_BOOT -> S_RUN unconditionally at the next edge.
- S_RUN, default: if_valid=1, if_pc=cur_pc, if_instr/if_imm pass-through. len=2 if instr[IMM_FLAG_BIT] else 1. mem_pc=(cur_pc+len) mod 2**Num_of_registers. cur_pc<=mem_pc.
- Priority in S_RUN is branch_taken > fault > stall > halt > advance.
- branch_taken: if_valid=0 (wrong-path kill), mem_pc=branch_target masked. Stall is ignored that cycle. Takes effect from S_HALT too (-> S_RUN).
- stall with if_valid: mem_pc=cur_pc (re-read), outputs hold, fetch_count unchanged.
- fault: a two-word instruction at cur_pc=2**Num_of_registers-1 sets fault=1, forces if_valid=0 and goes to S_HALT. fault clears only on rst.
- halt: if_instr[15:11]==HALT_OPCODE accepted (not stalled) -> HLT is presented valid this cycle, then S_HALT. S_HALT: mem_pc=cur_pc, if_valid=0, halted=1. Exit only by rst or branch_taken.
- fetch_count increments when if_valid & ~stall; it saturates at all ones.
- PC wraps: address 31, one-word -> next 0.
- Reset mid-stall or mid-halt: rst wins, same as reset.

Decomposition:
- Shared package: opcode field positions, HALT_OPCODE, IMM_FLAG_BIT, state encodings.
- One natural sub-module: fetch_next_pc (combinational next-address mux and masking). The FSM and counter stay in fetch_controller.

Test Plan:
- Reset then run over words 0:0x0010, 1:0x8020, 2:0x1234, 3:0x0030 -> if_pc 0,1,3 on consecutive cycles; at pc 1 if_two_word=1 and if_imm=0x1234; first if_valid 2 cycles after rst drops.
- Stall for 3 cycles while if_pc=1 -> mem_pc=1 and outputs frozen; fetch_count unchanged; resumes with if_pc=3.
- branch_taken with target 20, together with stall, at if_pc=3 -> if_valid=0 that cycle; next cycle if_pc=20, valid.
- HLT (0x0800) at pc 4 -> presented once valid, then halted=1 and if_valid=0 forever; branch_taken to 0 -> resumes at pc 0.
- Word 31 = 0x8000 -> fault=1, halted=1, if_valid=0; rst clears both; pc 31 one-word -> wraps to 0.
- Force fetch_count to all ones via a long loop -> stays 0xFFFF; rst -> 0.
